map_tile_store: RTL

- Parametrised successor to the single-client map RAM wrapper.
- Holds the W×H tile map in one inferred single-port RAM shared by two clients:
  - port A: game logic, read/write.
  - port B: renderer, read-only.
- A round-robin arbiter shares the RAM between the ports.
- A restore FSM copies the default layout from a ROM into the RAM after reset and on request, so a level can restart without reconfiguring the FPGA.

---
 rtl/map_pkg.sv | 47 ++++
 rtl/map_tile_store_if.sv | 38 +++
 rtl/map_layout_rom.sv | 30 +++
 rtl/map_tile_store.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared types, constants and helpers for the tile map store.
// Tile codes, default geometry, FSM states, address and layout helpers.
package map_pkg;

    localparam int MAP_W_DEF   = 21;
    localparam int MAP_H_DEF   = 21;
    localparam int COORD_W_DEF = 5;
    localparam int TILE_W_DEF  = 3;

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] WALL   = 3'd1;
    localparam logic [2:0] PELLET = 3'd2;
    localparam logic [2:0] POWER  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_DRAIN
    } map_state_e;

    function automatic logic [15:0] tile_addr(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] w
    );
        return y * w + x;
    endfunction

    function automatic logic in_range(input int x, input int y,
                                      input int w, input int h);
        return (x < w) && (y < h);
    endfunction

    // Built-in default level: border walls, even/even pillars,
    // power pellets near the corners, pellets everywhere else.
    function automatic logic [2:0] default_tile(input int x, input int y,
                                                input int w, input int h);
        if (x == 0 || y == 0 || x == w - 1 || y == h - 1)
            return WALL;
        if ((x % 2) == 0 && (y % 2) == 0)
            return WALL;
        if ((x == 1 || x == w - 2) && (y == 1 || y == h - 2))
            return POWER;
        return PELLET;
    endfunction

endpackage

// File: rtl/map_tile_store_if.sv
// Two-client tile map bus: port A read/write, port B read-only.
// master = client side, slave = map store side.
interface map_tile_store_if
    import map_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int TILE_W  = TILE_W_DEF
);
    logic               a_req;
    logic               a_we;
    logic [COORD_W-1:0] a_x;
    logic [COORD_W-1:0] a_y;
    logic [TILE_W-1:0]  a_wdata;
    logic               a_gnt;
    logic               a_rvalid;
    logic [TILE_W-1:0]  a_rdata;

    logic               b_req;
    logic [COORD_W-1:0] b_x;
    logic [COORD_W-1:0] b_y;
    logic               b_gnt;
    logic               b_rvalid;
    logic [TILE_W-1:0]  b_rdata;

    modport master (
        output a_req, a_we, a_x, a_y, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_x, b_y,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_x, a_y, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_x, b_y,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/map_layout_rom.sv
// Registered-output layout ROM, one cycle latency.
// An empty INIT_FILE name yields an all-EMPTY board.
module map_layout_rom
    import map_pkg::*;
#(
    parameter int    MAP_W     = MAP_W_DEF,
    parameter int    MAP_H     = MAP_H_DEF,
    parameter int    TILE_W    = TILE_W_DEF,
    parameter int    ADDR_W    = 9,
    parameter string INIT_FILE = "map_default.mif"
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [TILE_W-1:0] q
);
    localparam int N     = MAP_W * MAP_H;
    localparam bit BLANK = (INIT_FILE == "");

    logic [TILE_W-1:0] rom [N];

    for (genvar i = 0; i < N; i++) begin : g_rom
        assign rom[i] = BLANK ? '0 :
            TILE_W'(default_tile(i % MAP_W, i / MAP_W, MAP_W, MAP_H));
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        q <= rom[addr];
    end
endmodule

// File: rtl/map_tile_store.sv
// Tile map RAM shared by game logic (A, r/w) and renderer (B, r/o).
// Optional pellet counter enabled by defining MAP_PELLET_COUNT_EN.
module map_tile_store
    import map_pkg::*;
#(
    parameter int                MAP_W    = MAP_W_DEF,
    parameter int                MAP_H    = MAP_H_DEF,
    parameter int                COORD_W  = COORD_W_DEF,
    parameter int                TILE_W   = TILE_W_DEF,
    parameter logic [TILE_W-1:0] OOB_TILE = TILE_W'(WALL),
`ifdef MAP_PELLET_COUNT_EN
    parameter logic [TILE_W-1:0] PELLET_CODE = TILE_W'(PELLET),
`endif
    parameter string             INIT_FILE = "map_default.mif"
) (
    input  logic clock_50,
    input  logic reset_n,
    input  logic restore_req,
    output logic busy,
`ifdef MAP_PELLET_COUNT_EN
    output logic [$clog2(MAP_W*MAP_H+1)-1:0] pellet_count,
    output logic level_clear,
`endif
    map_tile_store_if.slave bus
);
    localparam int N      = MAP_W * MAP_H;
    localparam int ADDR_W = $clog2(N);
    localparam int CW     = ADDR_W + 1;

    map_state_e        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              last_b;
    logic              a_gnt, b_gnt;
    logic              a_in, b_in;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [TILE_W-1:0] ram_wdata, ram_q, rom_q;
    logic [TILE_W-1:0] mem [N];
    logic              a_rv, b_rv, a_oob_q, b_oob_q;
    logic [TILE_W-1:0] a_hold, b_hold, a_rd, b_rd;

    assign a_in = in_range(int'(bus.a_x), int'(bus.a_y), MAP_W, MAP_H);
    assign b_in = in_range(int'(bus.b_x), int'(bus.b_y), MAP_W, MAP_H);
    assign a_addr = ADDR_W'(tile_addr(16'(bus.a_x), 16'(bus.a_y), 16'(MAP_W)));
    assign b_addr = ADDR_W'(tile_addr(16'(bus.b_x), 16'(bus.b_y), 16'(MAP_W)));

    map_layout_rom #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .TILE_W(TILE_W),
        .ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)
    ) u_rom (
        .clk(clock_50),
        .addr(ADDR_W'(cnt)),
        .q(rom_q)
    );

    // Next state, arbitration and RAM port steering.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        ram_addr  = ADDR_W'(cnt - CW'(1));
        ram_we    = 1'b0;
        ram_wdata = rom_q;
        unique case (state)
            ST_IDLE: begin
                a_gnt = bus.a_req & (~bus.b_req | last_b);
                b_gnt = bus.b_req & (~bus.a_req | ~last_b);
                if (a_gnt) begin
                    ram_addr  = a_addr;
                    ram_we    = bus.a_we & a_in;
                    ram_wdata = bus.a_wdata;
                end else if (b_gnt) begin
                    ram_addr = b_addr;
                end
                if (restore_req) begin
                    state_n = ST_RESTORE;
                    cnt_n   = '0;
                end
            end
            ST_RESTORE: begin
                ram_we = (cnt != '0);
                cnt_n  = cnt + CW'(1);
                if (cnt == CW'(N - 1))
                    state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                ram_we  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_RESTORE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign bus.a_gnt = a_gnt;
    assign bus.b_gnt = b_gnt;

    // FSM, restore counter and round-robin history.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_RESTORE;
            cnt    <= '0;
            last_b <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (a_gnt || b_gnt)
                last_b <= b_gnt;
        end
    end

    // Single-port RAM with old-data read during write.
    always_ff @(posedge clock_50) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    assign a_rd = a_oob_q ? OOB_TILE : ram_q;
    assign b_rd = b_oob_q ? OOB_TILE : ram_q;
    assign bus.a_rvalid = a_rv;
    assign bus.b_rvalid = b_rv;
    assign bus.a_rdata  = a_rv ? a_rd : a_hold;
    assign bus.b_rdata  = b_rv ? b_rd : b_hold;

    // Read return pipeline; rdata holds until the next read.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            a_rv    <= 1'b0;
            b_rv    <= 1'b0;
            a_oob_q <= 1'b0;
            b_oob_q <= 1'b0;
            a_hold  <= '0;
            b_hold  <= '0;
        end else begin
            a_rv    <= a_gnt & ~bus.a_we;
            b_rv    <= b_gnt;
            a_oob_q <= ~a_in;
            b_oob_q <= ~b_in;
            if (a_rv)
                a_hold <= a_rd;
            if (b_rv)
                b_hold <= b_rd;
        end
    end

`ifdef MAP_PELLET_COUNT_EN
    localparam int PW = $clog2(N + 1);

    logic              pa_wr_q;
    logic [TILE_W-1:0] pa_new_q;
    logic [PW-1:0]     pcnt;

    // Pellet census: rebuilt on restore, tracked on port A writes.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            pa_wr_q  <= 1'b0;
            pa_new_q <= '0;
            pcnt     <= '0;
        end else begin
            pa_wr_q  <= a_gnt & bus.a_we & a_in;
            pa_new_q <= bus.a_wdata;
            if (state == ST_IDLE && state_n == ST_RESTORE) begin
                pcnt <= '0;
            end else if (state != ST_IDLE) begin
                if (ram_we && rom_q == PELLET_CODE)
                    pcnt <= pcnt + PW'(1);
            end else if (pa_wr_q) begin
                if (ram_q == PELLET_CODE && pa_new_q != PELLET_CODE)
                    pcnt <= pcnt - PW'(1);
                else if (ram_q != PELLET_CODE && pa_new_q == PELLET_CODE)
                    pcnt <= pcnt + PW'(1);
            end
        end
    end

    assign pellet_count = pcnt;
    assign level_clear  = ~busy & (pcnt == '0);
`endif
endmodule
